// File: rtl/demux_router_pkg.sv
// demux_router_pkg: shared constants and types for the demux router.
//   DEF_DATA_W    default beat width
//   lane_state_e  per-lane buffer state {EMPTY, FULL}
//   byte_t        one default-width data beat
package demux_router_pkg;
    localparam int DEF_DATA_W = 8;
    typedef enum logic {EMPTY, FULL} lane_state_e;
    typedef logic [DEF_DATA_W-1:0] byte_t;
endpackage

// File: rtl/demux_router_lane.sv
// demux_router_lane: one-entry holding buffer with valid/ready output handshake.
//   clk, rst  clock, synchronous active-high reset
//   load      write data into the buffer this cycle (wins over drain)
//   data      beat to load
//   ready     consumer accepts the held beat
//   valid     buffer full
//   q         held beat; keeps its last value while empty
module demux_router_lane
    import demux_router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] q
);
    lane_state_e state;

    assign valid = (state == FULL);

    // A load in the same cycle as a drain keeps the lane FULL with the new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            q     <= '0;
        end else if (load) begin
            state <= FULL;
            q     <= data;
        end else if (ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: rtl/demux_router.sv
// demux_router: registered 1-to-NUM_OUT demultiplexer with per-lane one-entry buffers.
//   clk, rst   clock, synchronous active-high reset
//   in_data    input beat; in_sel picks its lane; in_valid/in_ready handshake
//   out_data   lane i at [i*DATA_W +: DATA_W]; out_valid/out_ready per lane
//   err_sel    sticky flag for a beat with in_sel >= NUM_OUT; err_clr clears it (set wins)
//   stat_cnt   per-lane drained-beat counters, present only with DEMUX_ROUTER_STATS_EN
module demux_router
    import demux_router_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_OUT = 2,
    parameter int SEL_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
`ifdef DEMUX_ROUTER_STATS_EN
  , parameter int CNT_W   = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic                      err_sel,
    input  logic                      err_clr
`ifdef DEMUX_ROUTER_STATS_EN
  , output logic [NUM_OUT*CNT_W-1:0]  stat_cnt
`endif
);
    localparam int NP = 1 << SEL_W;

    logic          in_range;
    logic          accept;
    logic [NP-1:0] busy;

    // Padding to the full select range makes out-of-range selects read as not busy,
    // so such beats are always consumed (and dropped).
    assign busy     = NP'(out_valid & ~out_ready);
    assign in_range = int'(in_sel) < NUM_OUT;
    assign in_ready = !rst && !busy[in_sel];
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        demux_router_lane #(.DATA_W(DATA_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (accept && in_sel == SEL_W'(i)),
            .data  (in_data),
            .ready (out_ready[i]),
            .valid (out_valid[i]),
            .q     (out_data[i*DATA_W +: DATA_W])
        );
`ifdef DEMUX_ROUTER_STATS_EN
        always_ff @(posedge clk) begin
            if (rst)
                stat_cnt[i*CNT_W +: CNT_W] <= '0;
            else if (out_valid[i] && out_ready[i])
                stat_cnt[i*CNT_W +: CNT_W] <= stat_cnt[i*CNT_W +: CNT_W] + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_sel <= 1'b0;
        else if (accept && !in_range)
            err_sel <= 1'b1;
        else if (err_clr)
            err_sel <= 1'b0;
    end
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: directed self-checking bench for demux_router (NUM_OUT=3, DATA_W=8).
module tb_demux_router;
    localparam int DW = 8;
    localparam int NO = 3;
    localparam int SW = 2;
`ifdef DEMUX_ROUTER_STATS_EN
    localparam int CW = 4;
`endif

    logic             clk = 0;
    logic             rst;
    logic [DW-1:0]    in_data;
    logic [SW-1:0]    in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [NO*DW-1:0] out_data;
    logic [NO-1:0]    out_valid;
    logic [NO-1:0]    out_ready;
    logic             err_sel;
    logic             err_clr;
`ifdef DEMUX_ROUTER_STATS_EN
    logic [NO*CW-1:0] stat_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_router #(
        .DATA_W  (DW),
        .NUM_OUT (NO),
        .SEL_W   (SW)
`ifdef DEMUX_ROUTER_STATS_EN
      , .CNT_W   (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel),
        .err_clr   (err_clr)
`ifdef DEMUX_ROUTER_STATS_EN
      , .stat_cnt  (stat_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; in_data = '0; in_sel = '0; in_valid = 0; out_ready = '0; err_clr = 0;
        tick(); tick();
        rst = 0;
        // fill lane0 and raise err_sel, then reset over them
        in_valid = 1; in_sel = 0; in_data = 8'hA5;
        #1 chk("pre_ready", 32'(in_ready), 1);
        tick();
        chk("pre_valid", 32'(out_valid), 3'b001);
        chk("pre_data0", 32'(out_data[7:0]), 8'hA5);
        in_sel = 3; in_data = 8'h11;
        tick();
        in_valid = 0;
        chk("pre_err", 32'(err_sel), 1);
        rst = 1;
        #1 chk("rst_in_ready", 32'(in_ready), 0);
        tick(); tick();
        rst = 0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_err", 32'(err_sel), 0);

        // routing with consumers always ready
        out_ready = 3'b111;
        in_valid = 1; in_sel = 1; in_data = 8'h20;
        tick();
        chk("route_v1", 32'(out_valid), 3'b010);
        chk("route_d1", 32'(out_data[15:8]), 8'h20);
        in_sel = 0; in_data = 8'h10;
        tick();
        chk("route_v0", 32'(out_valid), 3'b001);
        chk("route_d0", 32'(out_data[7:0]), 8'h10);
        in_valid = 0;
        tick();
        chk("route_empty", 32'(out_valid), 0);
        chk("route_keep", 32'(out_data[7:0]), 8'h10);

        // backpressure on lane0
        out_ready = 3'b110;
        in_valid = 1; in_sel = 0; in_data = 8'h8C;
        #1 chk("bp_ready1", 32'(in_ready), 1);
        tick();
        chk("bp_v", 32'(out_valid), 3'b001);
        chk("bp_d", 32'(out_data[7:0]), 8'h8C);
        in_data = 8'h1D;
        #1 chk("bp_ready2", 32'(in_ready), 0);
        tick();
        chk("bp_hold", 32'(out_data[7:0]), 8'h8C);
        chk("bp_hold_v", 32'(out_valid), 3'b001);

        // lane1 still accepts while lane0 is stalled
        in_sel = 1; in_data = 8'h55;
        #1 chk("ind_ready", 32'(in_ready), 1);
        tick();
        chk("ind_v", 32'(out_valid), 3'b011);
        chk("ind_d", 32'(out_data[15:0]), 16'h558C);

        // release lane0: full-but-ready lane takes the retried beat
        in_sel = 0; in_data = 8'h1D; out_ready = 3'b111;
        #1 chk("rel_ready", 32'(in_ready), 1);
        tick();
        chk("rel_v", 32'(out_valid), 3'b001);
        chk("rel_d", 32'(out_data[7:0]), 8'h1D);
        in_valid = 0;
        tick();
        chk("rel_empty", 32'(out_valid), 0);

        // bad select
        in_valid = 1; in_sel = 3; in_data = 8'h77;
        #1 chk("bad_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        chk("bad_err", 32'(err_sel), 1);
        chk("bad_valid", 32'(out_valid), 0);
        chk("bad_data", out_data, 24'h00551D);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("clr_err", 32'(err_sel), 0);
        err_clr = 1; in_valid = 1; in_sel = 3;
        tick();
        err_clr = 0; in_valid = 0;
        chk("clr_set_wins", 32'(err_sel), 1);

        // sustained one beat per cycle on lane2
        in_valid = 1; in_sel = 2;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'(8'hC0 + k);
            #1 chk("sus_ready", 32'(in_ready), 1);
            tick();
            chk("sus_v", 32'(out_valid), 3'b100);
            chk("sus_d", 32'(out_data[23:16]), 32'(8'hC0 + k));
        end
        in_valid = 0;
        tick();
        chk("sus_empty", 32'(out_valid), 0);

`ifdef DEMUX_ROUTER_STATS_EN
        rst = 1;
        tick();
        rst = 0;
        chk("st_rst", stat_cnt, 0);
        in_valid = 1; in_sel = 1;
        for (int k = 0; k < 17; k++) begin
            in_data = 8'(k);
            tick();
        end
        in_valid = 0;
        tick();
        chk("st_lane1", 32'(stat_cnt[7:4]), 1);
        chk("st_lane0", 32'(stat_cnt[3:0]), 0);
        chk("st_lane2", 32'(stat_cnt[11:8]), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
